// File: rtl/pwm_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel_scheduler
// Purpose  : Four PWM channels with wrap-time shadow reload and debounced
//            push-button enable toggles.
// Revision : 1.0
// ============================================================================
module pwm_channel_scheduler #(
    parameter int W          = 28,
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_W      = 20
) (
    input  logic           clk_clk,
    input  logic           reset_reset,
    input  logic [4*W-1:0] period_in,
    input  logic [4*W-1:0] decode_in,
    input  logic [3:0]     push_in,
    output logic [3:0]     pwm_out,
    output logic [3:0]     chan_en,
    output logic [3:0]     wrap_pulse
);

    localparam logic [DEB_W-1:0] C_DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    for (genvar i = 0; i < 4; i++) begin : g_chan
        logic             r_sync1, r_sync2, r_deb, r_deb_d, r_en;
        logic [DEB_W-1:0] r_deb_cnt;
        logic [W-1:0]     r_cnt, r_sp, r_sc;
        logic             r_pwm, r_wrap;
        logic             w_run, w_last, w_press;
        logic [W-1:0]     w_per, w_dec;

        assign w_per   = period_in[i*W +: W];
        assign w_dec   = decode_in[i*W +: W];
        assign w_press = r_deb_d & ~r_deb;
        assign w_run   = r_en && (r_sp != '0);
        assign w_last  = (r_cnt == r_sp - W'(1));

        // Buttons are active-low, so synchroniser and debounced level rest at 1.
        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                r_sync1   <= 1'b1;
                r_sync2   <= 1'b1;
                r_deb     <= 1'b1;
                r_deb_d   <= 1'b1;
                r_deb_cnt <= '0;
            end else begin
                r_sync1 <= push_in[i];
                r_sync2 <= r_sync1;
                r_deb_d <= r_deb;
                if (r_sync2 != r_deb) begin
                    if (r_deb_cnt == C_DEB_LAST) begin
                        r_deb     <= r_sync2;
                        r_deb_cnt <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                    end
                end else begin
                    r_deb_cnt <= '0;
                end
            end
        end

        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                r_en <= 1'b0;
            end else if (w_press) begin
                r_en <= ~r_en;
            end
        end

        // Shadows track the PIO inputs while idle and reload only at wrap while running.
        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                r_cnt  <= '0;
                r_sp   <= '0;
                r_sc   <= '0;
                r_wrap <= 1'b0;
                r_pwm  <= 1'b0;
            end else begin
                r_pwm <= w_run && (r_cnt < r_sc);
                if (!w_run) begin
                    r_cnt  <= '0;
                    r_sp   <= w_per;
                    r_sc   <= w_dec;
                    r_wrap <= 1'b0;
                end else if (w_last) begin
                    r_cnt  <= '0;
                    r_sp   <= w_per;
                    r_sc   <= w_dec;
                    r_wrap <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt + W'(1);
                    r_wrap <= 1'b0;
                end
            end
        end

        assign pwm_out[i]    = r_pwm;
        assign chan_en[i]    = r_en;
        assign wrap_pulse[i] = r_wrap;
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_channel_scheduler
// Purpose  : Self-checking bench for pwm_channel_scheduler (DEB_CYCLES=4).
// Revision : 1.0
// ============================================================================
module tb_pwm_channel_scheduler;

    localparam int W = 28;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [W-1:0]   per [4];
    logic [W-1:0]   dec [4];
    logic [4*W-1:0] period_in;
    logic [4*W-1:0] decode_in;
    logic [3:0]     push_in = 4'hF;
    logic [3:0]     pwm_out;
    logic [3:0]     chan_en;
    logic [3:0]     wrap_pulse;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic pwm;
        logic wrap;
    } exp_t;
    exp_t q[$];

    typedef struct {
        int unsigned period;
        int unsigned decode;
        int unsigned periods;
    } vec_t;

    assign period_in = {per[3], per[2], per[1], per[0]};
    assign decode_in = {dec[3], dec[2], dec[1], dec[0]};

    pwm_channel_scheduler #(.W(W), .DEB_CYCLES(4), .DEB_W(3)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .period_in   (period_in),
        .decode_in   (decode_in),
        .push_in     (push_in),
        .pwm_out     (pwm_out),
        .chan_en     (chan_en),
        .wrap_pulse  (wrap_pulse)
    );

    initial forever #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Wait for the next wrap of a channel; a missing wrap counts as a failure.
    task automatic sync_wrap(input int ch, input string name);
        int n;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!wrap_pulse[ch] && n < 50);
        check({name, "_wrap_sync"}, 32'(wrap_pulse[ch]), 32'd1);
    endtask

    task automatic push_pattern(input int p, input int c, input int nper);
        for (int r = 0; r < nper; r++)
            for (int k = 0; k < p; k++)
                q.push_back('{pwm: (k < c), wrap: (k == p - 1)});
    endtask

    task automatic drain(input int ch, input int n, input string name);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            if (q.size() == 0) break;
            tick(1);
            e = q.pop_front();
            check({name, "_pwm"},  32'(pwm_out[ch]),    32'(e.pwm));
            check({name, "_wrap"}, 32'(wrap_pulse[ch]), 32'(e.wrap));
        end
    endtask

    // Holds the masked buttons low until chan_en changes, then releases them.
    task automatic press(input logic [3:0] mask, output int lat);
        logic [3:0] old;
        old = chan_en;
        push_in = push_in & ~mask;
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (chan_en == old && lat < 30);
        push_in = push_in | mask;
    endtask

    vec_t tbl [8];
    int   lat;

    initial begin
        tbl[0] = '{10, 3, 2};
        tbl[1] = '{5, 2, 2};
        tbl[2] = '{1, 0, 3};
        tbl[3] = '{10, 0, 1};
        tbl[4] = '{10, 12, 1};
        tbl[5] = '{4, 4, 2};
        tbl[6] = '{7, 6, 1};
        tbl[7] = '{3, 1, 2};
        for (int c = 0; c < 4; c++) begin
            per[c] = '0;
            dec[c] = '0;
        end

        #1 rst = 1'b1;
        #1;
        check("reset_pwm",  32'(pwm_out),    32'd0);
        check("reset_en",   32'(chan_en),    32'd0);
        check("reset_wrap", 32'(wrap_pulse), 32'd0);
        tick(3);
        rst = 1'b0;
        tick(2);

        // Enable channel 0 at 10/3.
        per[0] = 10;
        dec[0] = 3;
        press(4'b0001, lat);
        check("press0_latency", 32'(lat), 32'd7);
        check("press0_en", 32'(chan_en), 32'b0001);
        tick(10);

        for (int i = 0; i < 8; i++) begin
            per[0] = W'(tbl[i].period);
            dec[0] = W'(tbl[i].decode);
            sync_wrap(0, $sformatf("vec%0d", i));
            push_pattern(int'(tbl[i].period), int'(tbl[i].decode), int'(tbl[i].periods));
            drain(0, q.size(), $sformatf("vec%0d", i));
        end

        // Write 5/2 mid-period at cnt=4: the 10-cycle period finishes unchanged.
        per[0] = 10;
        dec[0] = 3;
        sync_wrap(0, "midwrite");
        push_pattern(10, 3, 1);
        push_pattern(5, 2, 2);
        drain(0, 4, "midwrite_old");
        per[0] = 5;
        dec[0] = 2;
        drain(0, q.size(), "midwrite_new");

        // Period 0 while enabled idles after the current period.
        per[0] = 0;
        sync_wrap(0, "per0");
        push_pattern(20, 0, 1);
        q[19].wrap = 1'b0;
        drain(0, q.size(), "per0_idle");

        // Channel 1: glitch rejected, press enables, mid-period press disables.
        per[1] = 10;
        dec[1] = 8;
        push_in[1] = 1'b0;
        tick(2);
        push_in[1] = 1'b1;
        tick(10);
        check("glitch_no_toggle", 32'(chan_en[1]), 32'd0);
        press(4'b0010, lat);
        check("press1_en", 32'(chan_en[1]), 32'd1);
        tick(10);
        sync_wrap(1, "ch1");
        tick(9);
        press(4'b0010, lat);
        check("press1_off_latency", 32'(lat), 32'd7);
        check("press1_off_en", 32'(chan_en[1]), 32'd0);
        check("press1_off_pwm_same", 32'(pwm_out[1]), 32'd1);
        tick(1);
        check("press1_off_pwm_next", 32'(pwm_out[1]), 32'd0);
        tick(10);
        check("ch1_idle_pwm", 32'(pwm_out[1]), 32'd0);
        press(4'b0010, lat);
        check("press1_reen", 32'(chan_en[1]), 32'd1);
        push_pattern(10, 8, 1);
        drain(1, q.size(), "reen");

        // Simultaneous presses on channels 2 and 3.
        press(4'b1100, lat);
        check("dual_latency", 32'(lat), 32'd7);
        check("dual_en", 32'(chan_en[3:2]), 32'b11);
        tick(10);

        // Asynchronous reset while channel 1 output is high.
        sync_wrap(1, "rst");
        tick(1);
        check("pre_rst_pwm", 32'(pwm_out[1]), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_pwm",  32'(pwm_out),    32'd0);
        check("async_rst_en",   32'(chan_en),    32'd0);
        check("async_rst_wrap", 32'(wrap_pulse), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
